image_stream_producer: RTL and testbench
========================================

Name: image_stream_producer

Overview:
- Next-generation raster pixel source. Converts VGA sync position (hcount, vcount, visible) into a pixel stream from an external image ROM or from internal test patterns.
- Adds over the previous generation:
  - integer upscaling (small ROM image shown at full screen);
  - a multiplier-free incremental address generator;
  - explicit ROM-latency compensation so data and valid are aligned;
  - frame/line markers and a frame counter.
- Feeds the downstream grayscale processing and display path.

Parameters:
- WIDTH, 640, visible pixels per line.
- HEIGHT, 480, visible lines per frame.
- PIX_W, 8, pixel bit width.
- CNT_W, 10, width of hcount/vcount.
- SCALE_SHIFT, 0, upscale factor 2^SCALE_SHIFT (0..3). Source image is SRC_W=WIDTH>>SCALE_SHIFT by SRC_H=HEIGHT>>SCALE_SHIFT.
- ROM_LATENCY, 1, read latency in cycles of the external ROM (1..3).
- ADDR_W, 19, ROM address width; must satisfy 2^ADDR_W >= SRC_W*SRC_H.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- hcount  in  CNT_W  current raster column.
- vcount  in  CNT_W  current raster row.
- visible  in  1  raster in active region.
- mode_in  in  2  source select: 0 ROM, 1 gradient, 2 checkerboard, 3 solid.
- solid_value  in  PIX_W  pixel value for mode 3.
- rom_addr  out  ADDR_W  registered ROM address.
- rom_q  in  PIX_W  ROM data, valid ROM_LATENCY cycles after rom_addr.
- pixel_out  out  PIX_W  output pixel.
- valid  out  1  pixel_out is valid.
- sof  out  1  first pixel of frame, aligned with valid.
- eol  out  1  last pixel of line, aligned with valid.
- frame_count  out  16  completed-frame counter.

Behaviour:
- Reset (reset==0 at a clk edge):
  - pixel_out, valid, sof, eol, rom_addr, frame_count and line_base are cleared to 0.
  - All pipeline valid bits are cleared.
  - The mode register is cleared to 0.
  - The armed flag is cleared.
- Arming after reset:
  - Frame start (FS) = visible && hcount==0 && vcount==0.
  - On FS the block sets armed=1.
  - Until armed, valid stays 0. A reset mid-frame therefore suppresses output until the next FS.
- Stage-0 qualification: in_px = armed_or_FS && visible && hcount<WIDTH && vcount<HEIGHT.
  - Out-of-range counts with visible=1 give valid=0.
  - rom_addr holds its value when in_px is 0.
- Mode latch: mode_in is sampled only on the FS cycle. mode changes mid-frame take effect at the next frame.
- Address generation (no multiplier):
  - src_x = hcount>>SCALE_SHIFT; src_y = vcount>>SCALE_SHIFT.
  - On FS, line_base is set to 0.
  - On the cycle visible falls, if vcount[SCALE_SHIFT-1:0] is all ones (always true when SCALE_SHIFT=0), line_base += SRC_W.
  - Stage 0 registers rom_addr = line_base + src_x, with width ADDR_W.
- Test patterns are computed in stage 0 from src_x/src_y:
  - gradient = src_x[PIX_W-1:0], wrapping modulo 2^PIX_W;
  - checker = (src_x[3]^src_y[3]) ? all-ones : 0;
  - solid = solid_value, sampled in stage 0.
- Pipeline and latency:
  - Pattern value, mode, in_px, sof and eol flags are delayed ROM_LATENCY cycles to align with rom_q.
  - An output register then selects rom_q or the pattern.
  - Total latency LAT = ROM_LATENCY+2 cycles from hcount/visible sample to pixel_out/valid, identical in every mode.
- Markers:
  - sof tag = FS.
  - eol tag = in_px && hcount==WIDTH-1.
  - Both are asserted only together with valid.
- frame_count increments by 1 on the cycle the pixel tagged eol on line HEIGHT-1 exits (valid && eol && last-line tag). It wraps from 0xFFFF to 0.
- Simultaneous reset and FS: reset wins.

Decomposition:
- Package image_stream_pkg holds:
  - mode enum (MODE_ROM, MODE_GRAD, MODE_CHECK, MODE_SOLID);
  - localparam helpers SRC_W, SRC_H, LAT;
  - checker cell size constant (8 source pixels).
- Sub-module pipe_delay: a parameterised width/depth shift register with synchronous active-low clear, used for the flag and pattern alignment.

Test Plan:
- Default params, ROM_LATENCY=1, mode 0, ROM model returns addr[7:0]; drive a full 800x525 raster -> first valid at cycle FS+3 with pixel 0x00, sof=1; pixel at (639,0) = 0x7F with eol=1; line 1 first rom_addr = 640.
- SCALE_SHIFT=1 -> rom_addr for (hcount,vcount) = (0,0),(1,0),(2,0),(0,1),(0,2) is 0,0,1,0,320; last address of frame = 76799.
- ROM_LATENCY=3, mode 1 -> latency 5 cycles; pixel at hcount=300 = 0x2C (300 mod 256); valid count per line = 640.
- mode_in changed from 0 to 3 mid-frame (solid_value=0xA5) -> current frame unchanged; next frame every pixel = 0xA5.
- reset pulsed low at (320,200) -> outputs 0 next cycle; valid stays 0 until next FS; frame_count=0 and increments to 1 only after the following complete frame.
- visible forced high with hcount=700 -> valid=0, rom_addr held; 65536 frames -> frame_count wraps to 0.

Source files
------------

// File: rtl/image_stream_pkg.sv
// Shared types and sizing helpers for the image stream producer.
// Holds the source-select enum, checkerboard cell size and pipeline tag layout.
package image_stream_pkg;

    typedef enum logic [1:0] {
        MODE_ROM   = 2'd0,
        MODE_GRAD  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_SOLID = 2'd3
    } mode_e;

    // Checkerboard cell edge in source pixels, and the source-coordinate bit that toggles it.
    localparam int unsigned CHECK_CELL = 8;
    localparam int unsigned CHECK_LOG2 = $clog2(CHECK_CELL);

    // Side data that travels alongside the ROM read.
    typedef struct packed {
        logic in_px;
        logic sof;
        logic eol;
        logic last_line;
        logic is_rom;
    } px_tag_t;

    function automatic int unsigned src_w_of(input int unsigned width, input int unsigned shift);
        return width >> shift;
    endfunction

    function automatic int unsigned src_h_of(input int unsigned height, input int unsigned shift);
        return height >> shift;
    endfunction

    function automatic int unsigned lat_of(input int unsigned rom_latency);
        return rom_latency + 2;
    endfunction

endpackage

// File: rtl/image_stream_producer_pipe_delay.sv
// Fixed-depth shift register with synchronous active-low clear.
// Aligns stage-0 side data with the ROM read data.
module pipe_delay #(
    parameter int unsigned W     = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    localparam int unsigned TOT_W = W * DEPTH;

    logic [TOT_W-1:0] stage_q;
    logic [TOT_W-1:0] stage_d;

    // Shift in at the bottom; the truncating cast drops the oldest entry.
    always_comb begin
        stage_d = TOT_W'({stage_q, d});
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[TOT_W-1 -: W];

endmodule

// File: rtl/image_stream_producer.sv
// Raster pixel source: turns sync position into an aligned pixel stream taken from
// an external image ROM (with integer upscaling) or from internal test patterns.
module image_stream_producer
    import image_stream_pkg::*;
#(
    parameter int unsigned WIDTH       = 640,
    parameter int unsigned HEIGHT      = 480,
    parameter int unsigned PIX_W       = 8,
    parameter int unsigned CNT_W       = 10,
    parameter int unsigned SCALE_SHIFT = 0,
    parameter int unsigned ROM_LATENCY = 1,
    parameter int unsigned ADDR_W      = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CNT_W-1:0]  hcount,
    input  logic [CNT_W-1:0]  vcount,
    input  logic              visible,
    input  logic [1:0]        mode_in,
    input  logic [PIX_W-1:0]  solid_value,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_q,
    output logic [PIX_W-1:0]  pixel_out,
    output logic              valid,
    output logic              sof,
    output logic              eol,
    output logic [15:0]       frame_count
);

    localparam int unsigned SRC_W = src_w_of(WIDTH, SCALE_SHIFT);
    // Checker bit in raster coordinates: source bit CHECK_LOG2 after the upscale shift.
    localparam int unsigned CHK_IDX = CHECK_LOG2 + SCALE_SHIFT;
    localparam logic [CNT_W-1:0] ROW_MASK = CNT_W'((1 << SCALE_SHIFT) - 1);

    logic              fs;
    logic              in_px;
    mode_e             mode_eff;
    logic [CNT_W-1:0]  src_x;
    logic [ADDR_W-1:0] base;

    logic              armed_q, armed_d;
    logic              visible_q, visible_d;
    mode_e             mode_q, mode_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [PIX_W-1:0]  pat_q, pat_d;
    px_tag_t           tag_q, tag_d;
    logic [PIX_W-1:0]  pixel_q, pixel_d;
    logic              valid_q, valid_d;
    logic              sof_q, sof_d;
    logic              eol_q, eol_d;
    logic [15:0]       frame_count_q, frame_count_d;

    logic [PIX_W-1:0]  pat_dly;
    px_tag_t           tag_dly;

    always_comb begin
        fs       = visible && (hcount == '0) && (vcount == '0);
        in_px    = (armed_q || fs) && visible &&
                   (hcount < CNT_W'(WIDTH)) && (vcount < CNT_W'(HEIGHT));
        mode_eff = fs ? mode_e'(mode_in) : mode_q;
        src_x    = hcount >> SCALE_SHIFT;
        // The FS pixel must address row 0 even though line_base clears on this same edge.
        base     = fs ? '0 : line_base_q;

        armed_d   = armed_q | fs;
        visible_d = visible;
        mode_d    = mode_eff;

        line_base_d = line_base_q;
        if (fs) begin
            line_base_d = '0;
        end else if (visible_q && !visible && ((vcount & ROW_MASK) == ROW_MASK)) begin
            line_base_d = line_base_q + ADDR_W'(SRC_W);
        end

        rom_addr_d = in_px ? (base + ADDR_W'(src_x)) : rom_addr_q;

        case (mode_eff)
            MODE_GRAD:  pat_d = PIX_W'(src_x);
            MODE_CHECK: pat_d = (hcount[CHK_IDX] ^ vcount[CHK_IDX]) ? '1 : '0;
            MODE_SOLID: pat_d = solid_value;
            default:    pat_d = '0;
        endcase

        tag_d           = '0;
        tag_d.in_px     = in_px;
        tag_d.sof       = fs;
        tag_d.eol       = in_px && (hcount == CNT_W'(WIDTH - 1));
        tag_d.last_line = (vcount == CNT_W'(HEIGHT - 1));
        tag_d.is_rom    = (mode_eff == MODE_ROM);

        // Output stage: data and markers leave together, gated by the delayed in_px.
        valid_d = tag_dly.in_px;
        sof_d   = tag_dly.in_px & tag_dly.sof;
        eol_d   = tag_dly.in_px & tag_dly.eol;
        pixel_d = pixel_q;
        if (tag_dly.in_px) begin
            pixel_d = tag_dly.is_rom ? rom_q : pat_dly;
        end

        frame_count_d = frame_count_q;
        if (tag_dly.in_px && tag_dly.eol && tag_dly.last_line) begin
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            armed_q       <= 1'b0;
            visible_q     <= 1'b0;
            mode_q        <= MODE_ROM;
            line_base_q   <= '0;
            rom_addr_q    <= '0;
            pat_q         <= '0;
            tag_q         <= '0;
            pixel_q       <= '0;
            valid_q       <= 1'b0;
            sof_q         <= 1'b0;
            eol_q         <= 1'b0;
            frame_count_q <= '0;
        end else begin
            armed_q       <= armed_d;
            visible_q     <= visible_d;
            mode_q        <= mode_d;
            line_base_q   <= line_base_d;
            rom_addr_q    <= rom_addr_d;
            pat_q         <= pat_d;
            tag_q         <= tag_d;
            pixel_q       <= pixel_d;
            valid_q       <= valid_d;
            sof_q         <= sof_d;
            eol_q         <= eol_d;
            frame_count_q <= frame_count_d;
        end
    end

    pipe_delay #(.W(PIX_W), .DEPTH(ROM_LATENCY)) u_pat_dly (
        .clk   (clk),
        .clr_n (reset),
        .d     (pat_q),
        .q     (pat_dly)
    );

    pipe_delay #(.W($bits(px_tag_t)), .DEPTH(ROM_LATENCY)) u_tag_dly (
        .clk   (clk),
        .clr_n (reset),
        .d     (tag_q),
        .q     (tag_dly)
    );

    assign rom_addr    = rom_addr_q;
    assign pixel_out   = pixel_q;
    assign valid       = valid_q;
    assign sof         = sof_q;
    assign eol         = eol_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_image_stream_producer.sv
// Directed bench: three producer configurations (default, 2x upscale, 3-cycle ROM)
// driven by one shared raster, each paired with a ROM model returning addr[7:0].
module tb_image_stream_producer;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  hcount, vcount;
    logic        visible;
    logic [1:0]  mode_a, mode_c;
    logic [7:0]  solid_value;

    logic [18:0] rom_addr_a, rom_addr_b, rom_addr_c;
    logic [7:0]  rom_q_a, rom_q_b, rom_q_c, c_p1, c_p2;
    logic [7:0]  pixel_a, pixel_b, pixel_c;
    logic        valid_a, valid_b, valid_c;
    logic        sof_a, sof_b, sof_c;
    logic        eol_a, eol_b, eol_c;
    logic [15:0] fc_a, fc_b, fc_c;

    int checks = 0;
    int errors = 0;
    int cnt_a, cnt_c;

    always #5 clk = ~clk;

    image_stream_producer dut_a (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .visible(visible),
        .mode_in(mode_a), .solid_value(solid_value), .rom_addr(rom_addr_a), .rom_q(rom_q_a),
        .pixel_out(pixel_a), .valid(valid_a), .sof(sof_a), .eol(eol_a), .frame_count(fc_a)
    );

    image_stream_producer #(.SCALE_SHIFT(1)) dut_b (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .visible(visible),
        .mode_in(mode_a), .solid_value(solid_value), .rom_addr(rom_addr_b), .rom_q(rom_q_b),
        .pixel_out(pixel_b), .valid(valid_b), .sof(sof_b), .eol(eol_b), .frame_count(fc_b)
    );

    image_stream_producer #(.ROM_LATENCY(3)) dut_c (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .visible(visible),
        .mode_in(mode_c), .solid_value(solid_value), .rom_addr(rom_addr_c), .rom_q(rom_q_c),
        .pixel_out(pixel_c), .valid(valid_c), .sof(sof_c), .eol(eol_c), .frame_count(fc_c)
    );

    always_ff @(posedge clk) begin
        rom_q_a <= rom_addr_a[7:0];
        rom_q_b <= rom_addr_b[7:0];
        c_p1    <= rom_addr_c[7:0];
        c_p2    <= c_p1;
        rom_q_c <= c_p2;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one raster position for one clock, then settle just past the edge.
    task automatic tick(input int h, input int v, input logic vis);
        hcount  = 10'(h);
        vcount  = 10'(v);
        visible = vis;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; mode_a = 2'd0; mode_c = 2'd1; solid_value = 8'hA5;
        hcount = '0; vcount = '0; visible = 1'b0;

        for (int i = 0; i < 3; i++) tick(0, 500, 1'b0);
        check("rst_pixel_a", 32'(pixel_a), 32'h0);
        check("rst_valid_a", 32'(valid_a), 32'h0);
        check("rst_sof_a",   32'(sof_a),   32'h0);
        check("rst_eol_a",   32'(eol_a),   32'h0);
        check("rst_addr_a",  32'(rom_addr_a), 32'h0);
        check("rst_fc_a",    32'(fc_a),    32'h0);
        check("rst_outs_b",  32'({pixel_b, valid_b, sof_b, eol_b, fc_b}), 32'h0);
        check("rst_outs_c",  32'({pixel_c, valid_c, sof_c, eol_c, fc_c}), 32'h0);
        check("rst_addr_c",  32'(rom_addr_c), 32'h0);

        // Visible pixel before any FS must not arm the block.
        reset = 1'b1;
        tick(5, 3, 1'b1);
        tick(0, 500, 1'b0);
        tick(0, 500, 1'b0);
        check("unarmed_valid_a", 32'(valid_a), 32'h0);
        check("unarmed_addr_a",  32'(rom_addr_a), 32'h0);

        // Frame 1, line 0, full width with blanking.
        cnt_a = 0; cnt_c = 0;
        for (int h = 0; h < 800; h++) begin
            tick(h, 0, h < 640);
            if (valid_a) cnt_a++;
            if (valid_c) cnt_c++;
            case (h)
                0: check("b_addr_0_0", 32'(rom_addr_b), 32'd0);
                1: begin
                    check("a_valid_fs2", 32'(valid_a), 32'h0);
                    check("b_addr_1_0",  32'(rom_addr_b), 32'd0);
                end
                2: begin
                    check("a_valid_fs3", 32'(valid_a), 32'h1);
                    check("a_sof_fs3",   32'(sof_a),   32'h1);
                    check("a_pix_fs3",   32'(pixel_a), 32'h00);
                    check("b_addr_2_0",  32'(rom_addr_b), 32'd1);
                end
                3: begin
                    check("a_sof_px1", 32'(sof_a),   32'h0);
                    check("a_pix_px1", 32'(pixel_a), 32'h01);
                    check("c_valid_fs4", 32'(valid_c), 32'h0);
                end
                4: begin
                    check("c_valid_fs5", 32'(valid_c), 32'h1);
                    check("c_sof_fs5",   32'(sof_c),   32'h1);
                end
                304: check("c_grad_300", 32'(pixel_c), 32'h2C);
                640: begin
                    check("a_pix_638", 32'(pixel_a), 32'h7E);
                    check("a_eol_638", 32'(eol_a),   32'h0);
                end
                641: begin
                    check("a_pix_639",   32'(pixel_a), 32'h7F);
                    check("a_eol_639",   32'(eol_a),   32'h1);
                    check("a_valid_639", 32'(valid_a), 32'h1);
                end
                642: check("a_valid_640", 32'(valid_a), 32'h0);
                default: ;
            endcase
        end
        check("a_valid_count_line0", 32'(cnt_a), 32'd640);
        check("c_valid_count_line0", 32'(cnt_c), 32'd640);

        // Line 1 full.
        for (int h = 0; h < 800; h++) begin
            tick(h, 1, h < 640);
            if (h == 0) begin
                check("a_addr_0_1", 32'(rom_addr_a), 32'd640);
                check("b_addr_0_1", 32'(rom_addr_b), 32'd0);
            end
        end

        // Line 2: request solid mid-frame; this frame must stay on ROM data.
        tick(0, 2, 1'b1);
        check("a_addr_0_2", 32'(rom_addr_a), 32'd1280);
        check("b_addr_0_2", 32'(rom_addr_b), 32'd320);
        mode_a = 2'd3;
        tick(10, 2, 1'b1);
        tick(11, 2, 1'b1);
        tick(12, 2, 1'b1);
        check("a_midframe_rom", 32'(pixel_a), 32'h0A);
        tick(640, 2, 1'b0);

        for (int v = 3; v < 479; v++) begin
            tick(0, v, 1'b1);
            tick(640, v, 1'b0);
        end

        tick(0, 479, 1'b1);
        tick(638, 479, 1'b1);
        tick(639, 479, 1'b1);
        check("a_addr_last", 32'(rom_addr_a), 32'd307199);
        check("b_addr_last", 32'(rom_addr_b), 32'd76799);
        check("a_fc_before_eof", 32'(fc_a), 32'd0);
        tick(640, 479, 1'b0);
        tick(640, 479, 1'b0);
        check("a_pix_last", 32'(pixel_a), 32'hFF);
        check("a_eol_last", 32'(eol_a),   32'h1);
        check("a_fc_frame1", 32'(fc_a), 32'd1);
        for (int i = 0; i < 4; i++) tick(0, 500, 1'b0);

        // Frame 2 picks up the solid mode.
        for (int h = 0; h < 12; h++) begin
            tick(h, 0, 1'b1);
            if (h >= 2) begin
                check("a_solid_pix",   32'(pixel_a), 32'hA5);
                check("a_solid_valid", 32'(valid_a), 32'h1);
            end
        end

        // Reset mid-frame at (320,200).
        tick(319, 200, 1'b1);
        check("a_fc_prereset", 32'(fc_a), 32'd1);
        reset = 1'b0;
        tick(320, 200, 1'b1);
        reset = 1'b1;
        check("a_postrst_valid", 32'(valid_a), 32'h0);
        check("a_postrst_pix",   32'(pixel_a), 32'h0);
        check("a_postrst_addr",  32'(rom_addr_a), 32'h0);
        check("a_postrst_fc",    32'(fc_a), 32'd0);
        for (int h = 321; h < 331; h++) begin
            tick(h, 200, 1'b1);
            check("a_postrst_quiet", 32'(valid_a), 32'h0);
        end
        tick(639, 479, 1'b1);
        for (int i = 0; i < 3; i++) tick(640, 479, 1'b0);
        check("a_partial_fc", 32'(fc_a), 32'd0);
        check("a_partial_valid", 32'(valid_a), 32'h0);

        // Frame 3 re-arms.
        tick(0, 0, 1'b1);
        tick(1, 0, 1'b1);
        tick(2, 0, 1'b1);
        check("a_rearm_valid", 32'(valid_a), 32'h1);
        check("a_rearm_sof",   32'(sof_a),   32'h1);
        check("a_rearm_pix",   32'(pixel_a), 32'hA5);
        tick(639, 479, 1'b1);
        check("a_addr_639", 32'(rom_addr_a), 32'd639);
        check("a_fc_pre_frame3", 32'(fc_a), 32'd0);

        // hcount beyond WIDTH with visible held high.
        tick(700, 10, 1'b1);
        tick(700, 10, 1'b1);
        check("a_fc_frame3", 32'(fc_a), 32'd1);
        check("a_eol_frame3", 32'(eol_a), 32'h1);
        tick(700, 10, 1'b1);
        check("a_oor_h_valid", 32'(valid_a), 32'h0);
        check("a_oor_h_addr",  32'(rom_addr_a), 32'd639);
        for (int i = 0; i < 3; i++) tick(5, 480, 1'b1);
        check("a_oor_v_valid", 32'(valid_a), 32'h0);
        check("a_oor_v_addr",  32'(rom_addr_a), 32'd639);

        // Frame counter wrap: one last-line eol pixel per clock.
        for (int i = 0; i < 65534; i++) tick(639, 479, 1'b1);
        for (int i = 0; i < 3; i++) tick(640, 479, 1'b0);
        check("a_fc_ffff", 32'(fc_a), 32'hFFFF);
        tick(639, 479, 1'b1);
        for (int i = 0; i < 3; i++) tick(640, 479, 1'b0);
        check("a_fc_wrap", 32'(fc_a), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
